// File: rtl/reg32_bist.sv
// Built-in self-test for a 32-bit resettable register: checks reset value, then LFSR data vectors.
// Optional REG32_BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module reg32_bist #(
    parameter int unsigned NUM_VECTORS = 16,
    parameter logic [31:0] SEED        = 32'h0000005E
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        dut_reset,
    output logic [31:0] dut_d,
    input  logic [31:0] dut_q,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [7:0]  fail_index
);

    localparam logic [31:0] LfsrMask = 32'h80200003;
    localparam logic [31:0] SeedEff  = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [7:0]  LastIdx  = 8'(NUM_VECTORS - 1);

`ifdef REG32_BIST_STOP_ON_FAIL_EN
    localparam bit StopOnFail = 1'b1;
`else
    localparam bit StopOnFail = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StRchk,
        StDrive,
        StCheck,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [7:0]  vec_q, vec_d;
    logic [7:0]  err_q, err_d;
    logic [7:0]  fidx_q, fidx_d;
    logic [31:0] expected;
    logic        mismatch;
    logic        accept;

    // Register under test must read back 0 after reset, then the vector driven last cycle.
    always_comb begin
        expected = (state_q == StCheck) ? lfsr_q : 32'd0;
        mismatch = ((state_q == StRchk) || (state_q == StCheck)) && (dut_q != expected);
        accept   = ((state_q == StIdle) || (state_q == StDone)) && start;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) state_d = StRst;
            end
            StRst:   state_d = StRchk;
            StRchk:  state_d = (StopOnFail && mismatch) ? StDone : StDrive;
            StDrive: state_d = StCheck;
            StCheck: begin
                if ((vec_q == LastIdx) || (StopOnFail && mismatch)) begin
                    state_d = StDone;
                end else begin
                    state_d = StDrive;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        lfsr_d = lfsr_q;
        vec_d  = vec_q;
        err_d  = err_q;
        fidx_d = fidx_q;
        if (accept) begin
            lfsr_d = SeedEff;
            vec_d  = 8'd0;
            err_d  = 8'd0;
            fidx_d = 8'd0;
        end
        if (state_q == StCheck) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrMask : 32'd0);
            vec_d  = vec_q + 8'd1;
        end
        if (mismatch) begin
            if (err_q == 8'd0) begin
                fidx_d = (state_q == StRchk) ? 8'hFF : vec_q;
            end
            if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SeedEff;
            vec_q  <= 8'd0;
            err_q  <= 8'd0;
            fidx_q <= 8'd0;
        end else begin
            lfsr_q <= lfsr_d;
            vec_q  <= vec_d;
            err_q  <= err_d;
            fidx_q <= fidx_d;
        end
    end

    always_comb begin
        busy       = (state_q == StRst) || (state_q == StRchk) ||
                     (state_q == StDrive) || (state_q == StCheck);
        done       = (state_q == StDone);
        pass       = done && (err_q == 8'd0);
        dut_reset  = reset || (state_q == StRst);
        dut_d      = ((state_q == StDrive) || (state_q == StCheck)) ? lfsr_q : 32'd0;
        err_count  = err_q;
        fail_index = fidx_q;
    end

endmodule

// File: tb/tb_reg32_bist.sv
// Self-checking bench for reg32_bist: behavioural register with stuck-at faults and a run model.
module tb_reg32_bist;

    localparam int unsigned NA    = 4;
    localparam logic [31:0] SEEDA = 32'd94;
    localparam int unsigned NB    = 255;
    localparam logic [31:0] SEEDB = 32'd0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start_a, start_b;
    logic        dut_reset_a, busy_a, done_a, pass_a;
    logic        dut_reset_b, busy_b, done_b, pass_b;
    logic [31:0] dut_d_a, dut_q_a, dut_d_b, dut_q_b;
    logic [7:0]  err_a, fidx_a, err_b, fidx_b;
    logic [31:0] reg_a, reg_b, m1_a, m0_a, m1_b, m0_b;

    int checks = 0;
    int errors = 0;

    reg32_bist #(.NUM_VECTORS(NA), .SEED(SEEDA)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .dut_reset(dut_reset_a), .dut_d(dut_d_a),
        .dut_q(dut_q_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .fail_index(fidx_a)
    );

    reg32_bist #(.NUM_VECTORS(NB), .SEED(SEEDB)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .dut_reset(dut_reset_b), .dut_d(dut_d_b),
        .dut_q(dut_q_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .fail_index(fidx_b)
    );

    // Registers under test; m1/m0 plant stuck-at-1 / stuck-at-0 bits on the output.
    always_ff @(posedge clk) begin
        if (dut_reset_a) reg_a <= '0;
        else reg_a <= dut_d_a;
        if (dut_reset_b) reg_b <= '0;
        else reg_b <= dut_d_b;
    end
    assign dut_q_a = (reg_a | m1_a) & ~m0_a;
    assign dut_q_b = (reg_b | m1_b) & ~m0_b;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h80200003 : 32'd0);
    endfunction

    function automatic logic [31:0] vec_at(input logic [31:0] seed, input int k);
        logic [31:0] v;
        v = (seed == 32'd0) ? 32'd1 : seed;
        for (int i = 0; i < k; i++) v = lfsr_step(v);
        return v;
    endfunction

    // Expected outcome of a run: cycles counted from the accept edge to the edge raising done.
    task automatic model(input int n, input logic [31:0] seed, input logic [31:0] m1,
                         input logic [31:0] m0, output int ee, output int ef, output int ec);
        logic        stop;
        logic [31:0] v;
`ifdef REG32_BIST_STOP_ON_FAIL_EN
        stop = 1'b1;
`else
        stop = 1'b0;
`endif
        ee = 0;
        ef = 0;
        ec = 2 * n + 2;
        if ((m1 & ~m0) != 32'd0) begin
            ee = 1;
            ef = 255;
            if (stop) ec = 2;
        end
        for (int k = 0; k < n; k++) begin
            if (stop && ee != 0) break;
            v = vec_at(seed, k);
            if (((v | m1) & ~m0) != v) begin
                if (ee == 0) ef = k;
                if (ee < 255) ee++;
                if (stop) ec = 4 + 2 * k;
            end
        end
    endtask

    task automatic run_a(input string name, input logic [31:0] m1, input logic [31:0] m0);
        int ee, ef, ec, cnt;
        logic [31:0] v;
        model(NA, SEEDA, m1, m0, ee, ef, ec);
        m1_a = m1;
        m0_a = m0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        cnt = 0;
        while (done_a !== 1'b1 && cnt < ec + 20) begin
            if (cnt == 0) begin
                checks++;
                if (dut_reset_a !== 1'b1 || dut_d_a !== 32'd0 || busy_a !== 1'b1 ||
                    done_a !== 1'b0) begin
                    errors++;
                    $display("FAIL %s rst_phase: rst=%b d=%h busy=%b done=%b want 1 0 1 0",
                             name, dut_reset_a, dut_d_a, busy_a, done_a);
                end
            end else if (cnt == 1) begin
                checks++;
                if (dut_reset_a !== 1'b0 || dut_d_a !== 32'd0) begin
                    errors++;
                    $display("FAIL %s rchk_phase: rst=%b d=%h want 0 0", name, dut_reset_a,
                             dut_d_a);
                end
            end else begin
                v = vec_at(SEEDA, (cnt - 2) / 2);
                checks++;
                if (dut_d_a !== v || busy_a !== 1'b1) begin
                    errors++;
                    $display("FAIL %s dut_d cyc%0d: got %h busy=%b want %h busy=1", name, cnt,
                             dut_d_a, busy_a, v);
                end
            end
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt != ec) begin
            errors++;
            $display("FAIL %s run_cycles: got %0d want %0d", name, cnt, ec);
        end
        checks++;
        if (err_a !== 8'(ee) || fidx_a !== 8'(ef) || pass_a !== (ee == 0) || busy_a !== 1'b0 ||
            dut_d_a !== 32'd0) begin
            errors++;
            $display("FAIL %s result: err=%0d fidx=%h pass=%b busy=%b d=%h want %0d %h %b 0 0",
                     name, err_a, fidx_a, pass_a, busy_a, dut_d_a, ee, 8'(ef), ee == 0);
        end
    endtask

    task automatic run_b(input string name, input logic [31:0] m1, input logic [31:0] m0);
        int ee, ef, ec, cnt;
        model(NB, SEEDB, m1, m0, ee, ef, ec);
        m1_b = m1;
        m0_b = m0;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        cnt = 0;
        while (done_b !== 1'b1 && cnt < ec + 20) begin
            if (cnt == 2) begin
                checks++;
                if (dut_d_b !== 32'd1) begin
                    errors++;
                    $display("FAIL %s zero_seed: got %h want 00000001", name, dut_d_b);
                end
            end
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt != ec || err_b !== 8'(ee) || fidx_b !== 8'(ef) || pass_b !== 1'b0) begin
            errors++;
            $display("FAIL %s result: cyc=%0d err=%0d fidx=%h pass=%b want %0d %0d %h 0",
                     name, cnt, err_b, fidx_b, pass_b, ec, ee, 8'(ef));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0 || err_a !== 8'd0 ||
            fidx_a !== 8'd0 || dut_reset_a !== 1'b1 || dut_d_a !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b pass=%b err=%0d fidx=%h rst=%b d=%h",
                     busy_a, done_a, pass_a, err_a, fidx_a, dut_reset_a, dut_d_a);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_reset_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_state: rst=%b busy=%b done=%b want 0 0 0", dut_reset_a, busy_a,
                     done_a);
        end
    endtask

    task automatic test_done_hold();
        repeat (3) @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || pass_a !== 1'b1 || err_a !== 8'd0) begin
            errors++;
            $display("FAIL done_hold: done=%b busy=%b pass=%b err=%0d want 1 0 1 0", done_a,
                     busy_a, pass_a, err_a);
        end
    endtask

    task automatic test_random();
        logic [31:0] m1, m0;
        for (int i = 0; i < 8; i++) begin
            m1 = $urandom & $urandom & $urandom & $urandom;
            m0 = $urandom & $urandom & $urandom & $urandom;
            run_a($sformatf("rand%0d", i), m1, m0);
        end
    endtask

    task automatic test_abort();
        logic [31:0] v;
`ifdef REG32_BIST_STOP_ON_FAIL_EN
        m0_a = 32'd0;
`else
        m0_a = 32'hFFFFFFFF;
`endif
        m1_a = 32'd0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (5) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        v = vec_at(SEEDA, 2);
        checks++;
        if (busy_a !== 1'b1 || dut_d_a !== v || dut_reset_a !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored: busy=%b d=%h rst=%b want 1 %h 0", busy_a, dut_d_a,
                     dut_reset_a, v);
        end
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || err_a !== 8'd0 || fidx_a !== 8'd0 ||
            pass_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b err=%0d fidx=%h pass=%b want all 0",
                     busy_a, done_a, err_a, fidx_a, pass_a);
        end
        run_a("after_abort", 32'd0, 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        m1_a    = '0;
        m0_a    = '0;
        m1_b    = '0;
        m0_b    = 32'hFFFFFFFF;
        test_reset();
        run_a("good_reg", 32'd0, 32'd0);
        test_done_hold();
        run_a("tie_zero", 32'd0, 32'hFFFFFFFF);
        run_a("tie_ones", 32'hFFFFFFFF, 32'd0);
        test_random();
        test_abort();
        run_b("long_tie_zero", 32'd0, 32'hFFFFFFFF);
        run_b("long_tie_ones", 32'hFFFFFFFF, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
